// File: rtl/dma_copy_pkg.sv
// rtl/dma_copy_pkg.sv - shared types and constants for the DMA copy engine
package dma_copy_pkg;

    // Copy sequencer: one word per RD -> LAT -> WR pass.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        LAT  = 2'd2,
        WR   = 2'd3
    } state_t;

    // CSR word offsets
    localparam logic [1:0] CSR_CTRL = 2'd0;
    localparam logic [1:0] CSR_SRC  = 2'd1;
    localparam logic [1:0] CSR_DST  = 2'd2;
    localparam logic [1:0] CSR_LEN  = 2'd3;

    // CTRL write bit positions
    localparam int START   = 0;
    localparam int ABORT   = 1;
    localparam int IRQ_EN  = 2;
    localparam int CLEAR   = 3;

    // CTRL read (status) bit positions
    localparam int BUSY    = 0;
    localparam int DONE    = 1;
    localparam int ABORTED = 3;

endpackage

// File: rtl/dma_copy_csr.sv
// rtl/dma_copy_csr.sv - CSR register file, command pulses and interrupt
//
// Ports:
//   clk, reset_n                 clock, async active-low reset
//   csr_*                        Avalon-MM slave, registered read data
//   irq                          done & irq_en
//   busy                         engine is mid-copy (blocks config writes)
//   set_done/set_aborted         status set requests from the sequencer
//   clr_status                   accepted start with non-zero length
//   len_dec                      one word committed, decrement LEN
//   start_pulse/abort_pulse      decoded CTRL commands
//   src/dst/len                  programmed copy parameters
module dma_copy_csr
    import dma_copy_pkg::*;
#(
    parameter int ADDR_W = 11,
    parameter int LEN_W  = 12
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [1:0]        csr_address,
    input  logic              csr_chipselect,
    input  logic              csr_write,
    input  logic [31:0]       csr_writedata,
    input  logic              csr_read,
    output logic [31:0]       csr_readdata,
    output logic              irq,
    input  logic              busy,
    input  logic              set_done,
    input  logic              set_aborted,
    input  logic              clr_status,
    input  logic              len_dec,
    output logic              start_pulse,
    output logic              abort_pulse,
    output logic [ADDR_W-1:0] src,
    output logic [ADDR_W-1:0] dst,
    output logic [LEN_W-1:0]  len
);

    logic        wr_ctrl;
    logic        ctrl_blocked;
    logic        ctrl_apply;
    logic        done_q;
    logic        aborted_q;
    logic        irq_en_q;
    logic [31:0] rd_mux;
    logic        unused_wdata;

    assign unused_wdata = &{1'b0, csr_writedata[31:LEN_W]};

    assign wr_ctrl      = csr_chipselect & csr_write & (csr_address == CSR_CTRL);
    // A start written while busy discards the whole CTRL write (irq_en, clear)
    assign ctrl_blocked = busy & csr_writedata[START];
    assign ctrl_apply   = wr_ctrl & ~ctrl_blocked;

    // Abort wins over start in the same write
    assign start_pulse  = wr_ctrl & csr_writedata[START] & ~csr_writedata[ABORT] & ~busy;
    assign abort_pulse  = wr_ctrl & csr_writedata[ABORT];

    assign irq = done_q & irq_en_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            src       <= '0;
            dst       <= '0;
            len       <= '0;
            irq_en_q  <= 1'b0;
            done_q    <= 1'b0;
            aborted_q <= 1'b0;
        end else begin
            if (csr_chipselect && csr_write && !busy) begin
                case (csr_address)
                    CSR_SRC: src <= csr_writedata[ADDR_W-1:0];
                    CSR_DST: dst <= csr_writedata[ADDR_W-1:0];
                    CSR_LEN: len <= csr_writedata[LEN_W-1:0];
                    default: ;
                endcase
            end else if (len_dec) begin
                len <= len - LEN_W'(1);
            end

            if (ctrl_apply) begin
                irq_en_q <= csr_writedata[IRQ_EN];
            end

            if (set_done) begin
                done_q <= 1'b1;
            end else if (clr_status || (ctrl_apply && csr_writedata[CLEAR])) begin
                done_q <= 1'b0;
            end

            if (set_aborted) begin
                aborted_q <= 1'b1;
            end else if (clr_status || (ctrl_apply && csr_writedata[CLEAR])) begin
                aborted_q <= 1'b0;
            end
        end
    end

    always_comb begin
        rd_mux = '0;
        case (csr_address)
            CSR_CTRL: begin
                rd_mux[BUSY]    = busy;
                rd_mux[DONE]    = done_q;
                rd_mux[IRQ_EN]  = irq_en_q;
                rd_mux[ABORTED] = aborted_q;
            end
            CSR_SRC: rd_mux = 32'(src);
            CSR_DST: rd_mux = 32'(dst);
            CSR_LEN: rd_mux = 32'(len);
            default: rd_mux = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            csr_readdata <= '0;
        end else if (csr_chipselect && csr_read) begin
            csr_readdata <= rd_mux;
        end
    end

endmodule

// File: rtl/dma_copy_engine.sv
// rtl/dma_copy_engine.sv - memory-to-memory word copy engine on RAM port s2
//
// Ports:
//   clk, reset_n        clock (shared with RAM s2), async active-low reset
//   csr_*               four-register CSR slave: CTRL/STATUS, SRC, DST, LEN
//   irq                 level interrupt, done & irq_en
//   mem_*               RAM port s2 master; address registered in the RAM,
//                       read data returned unregistered one cycle later
module dma_copy_engine
    import dma_copy_pkg::*;
#(
    parameter int ADDR_W = 11,
    parameter int DATA_W = 32,
    parameter int LEN_W  = 12
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [1:0]        csr_address,
    input  logic              csr_chipselect,
    input  logic              csr_write,
    input  logic [31:0]       csr_writedata,
    input  logic              csr_read,
    output logic [31:0]       csr_readdata,
    output logic              irq,
    output logic [ADDR_W-1:0] mem_address,
    output logic [3:0]        mem_byteenable,
    output logic              mem_chipselect,
    output logic              mem_write,
    output logic [DATA_W-1:0] mem_writedata,
    input  logic [DATA_W-1:0] mem_readdata,
    output logic              mem_clken
);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] src_ptr, dst_ptr;
    logic [DATA_W-1:0] data_q;
    logic [ADDR_W-1:0] src, dst;
    logic [LEN_W-1:0]  len;
    logic              busy;
    logic              start_pulse, abort_pulse;
    logic              set_done, set_aborted, clr_status, len_dec;
    logic              load_ptrs, inc_ptrs;

    assign busy           = (state_q != IDLE);
    assign mem_byteenable = 4'hF;
    assign mem_clken      = 1'b1;
    assign mem_writedata  = data_q;

    dma_copy_csr #(
        .ADDR_W (ADDR_W),
        .LEN_W  (LEN_W)
    ) u_csr (
        .clk            (clk),
        .reset_n        (reset_n),
        .csr_address    (csr_address),
        .csr_chipselect (csr_chipselect),
        .csr_write      (csr_write),
        .csr_writedata  (csr_writedata),
        .csr_read       (csr_read),
        .csr_readdata   (csr_readdata),
        .irq            (irq),
        .busy           (busy),
        .set_done       (set_done),
        .set_aborted    (set_aborted),
        .clr_status     (clr_status),
        .len_dec        (len_dec),
        .start_pulse    (start_pulse),
        .abort_pulse    (abort_pulse),
        .src            (src),
        .dst            (dst),
        .len            (len)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // The LEN register doubles as the remaining-word counter.
    always_comb begin
        state_d        = state_q;
        set_done       = 1'b0;
        set_aborted    = 1'b0;
        clr_status     = 1'b0;
        len_dec        = 1'b0;
        load_ptrs      = 1'b0;
        inc_ptrs       = 1'b0;
        mem_chipselect = 1'b0;
        mem_write      = 1'b0;
        mem_address    = src_ptr;
        case (state_q)
            IDLE: begin
                if (start_pulse) begin
                    if (len == '0) begin
                        set_done = 1'b1;
                    end else begin
                        clr_status = 1'b1;
                        load_ptrs  = 1'b1;
                        state_d    = RD;
                    end
                end
            end
            RD: begin
                mem_chipselect = 1'b1;
                state_d        = LAT;
            end
            LAT: begin
                state_d = WR;
            end
            WR: begin
                mem_chipselect = 1'b1;
                mem_write      = 1'b1;
                mem_address    = dst_ptr;
                len_dec        = 1'b1;
                inc_ptrs       = 1'b1;
                if (len == LEN_W'(1)) begin
                    set_done = 1'b1;
                    state_d  = IDLE;
                end else begin
                    state_d  = RD;
                end
            end
            default: state_d = IDLE;
        endcase
        // A write already on the bus in WR still commits; only sequencing stops.
        if (busy && abort_pulse) begin
            state_d     = IDLE;
            set_done    = 1'b0;
            set_aborted = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            src_ptr <= '0;
            dst_ptr <= '0;
            data_q  <= '0;
        end else begin
            if (load_ptrs) begin
                src_ptr <= src;
                dst_ptr <= dst;
            end else if (inc_ptrs) begin
                src_ptr <= src_ptr + ADDR_W'(1);
                dst_ptr <= dst_ptr + ADDR_W'(1);
            end
            // RAM output is valid in LAT because its address was registered in RD
            if (state_q == LAT) begin
                data_q <= mem_readdata;
            end
        end
    end

endmodule

// File: tb/tb_dma_copy_engine.sv
// tb/tb_dma_copy_engine.sv - self-checking bench for dma_copy_engine
module tb_dma_copy_engine;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [1:0]  csr_address = 2'd0;
    logic        csr_chipselect = 1'b0;
    logic        csr_write = 1'b0;
    logic [31:0] csr_writedata = 32'd0;
    logic        csr_read = 1'b0;
    logic [31:0] csr_readdata;
    logic        irq;
    logic [10:0] mem_address;
    logic [3:0]  mem_byteenable;
    logic        mem_chipselect;
    logic        mem_write;
    logic [31:0] mem_writedata;
    logic [31:0] mem_readdata;
    logic        mem_clken;

    int n_checks = 0;
    int n_fail = 0;
    int cyc = 0;
    int cs_count = 0;
    int wr_count = 0;
    bit sb_bypass = 1'b0;

    logic [42:0] exp_wr_q [$];
    logic [10:0] exp_rd_q [$];
    logic [31:0] ref_mem [0:2047];

    // RAM model for port s2: registered address, unregistered data out
    logic [31:0] ram [0:2047];
    logic [10:0] ram_addr_q = 11'd0;
    logic        pl_en = 1'b0;
    logic [10:0] pl_addr = 11'd0;
    logic [31:0] pl_data = 32'd0;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (pl_en) ram[pl_addr] <= pl_data;
        if (mem_chipselect) begin
            ram_addr_q <= mem_address;
            if (mem_write) ram[mem_address] <= mem_writedata;
        end
    end
    assign mem_readdata = ram[ram_addr_q];

    dma_copy_engine dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .csr_address    (csr_address),
        .csr_chipselect (csr_chipselect),
        .csr_write      (csr_write),
        .csr_writedata  (csr_writedata),
        .csr_read       (csr_read),
        .csr_readdata   (csr_readdata),
        .irq            (irq),
        .mem_address    (mem_address),
        .mem_byteenable (mem_byteenable),
        .mem_chipselect (mem_chipselect),
        .mem_write      (mem_write),
        .mem_writedata  (mem_writedata),
        .mem_readdata   (mem_readdata),
        .mem_clken      (mem_clken)
    );

    // Scoreboard monitor: every s2 access is popped against the expected stream
    always @(negedge clk) begin
        logic [42:0] ew;
        logic [10:0] er;
        if (reset_n && mem_chipselect) begin
            cs_count = cs_count + 1;
            if (mem_write) wr_count = wr_count + 1;
            if (!sb_bypass) begin
                n_checks = n_checks + 1;
                if (mem_write) begin
                    if (exp_wr_q.size() == 0) begin
                        n_fail = n_fail + 1;
                        $display("FAIL sb_write unexpected addr=%h data=%h", mem_address, mem_writedata);
                    end else begin
                        ew = exp_wr_q.pop_front();
                        if ({mem_address, mem_writedata} !== ew) begin
                            n_fail = n_fail + 1;
                            $display("FAIL sb_write got addr=%h data=%h required addr=%h data=%h",
                                     mem_address, mem_writedata, ew[42:32], ew[31:0]);
                        end
                    end
                end else begin
                    if (exp_rd_q.size() == 0) begin
                        n_fail = n_fail + 1;
                        $display("FAIL sb_read unexpected addr=%h", mem_address);
                    end else begin
                        er = exp_rd_q.pop_front();
                        if (mem_address !== er) begin
                            n_fail = n_fail + 1;
                            $display("FAIL sb_read got addr=%h required %h", mem_address, er);
                        end
                    end
                end
            end
        end
    end

    task automatic csr_wr(input logic [1:0] a, input logic [31:0] d);
        @(negedge clk);
        csr_chipselect = 1'b1; csr_write = 1'b1; csr_address = a; csr_writedata = d;
        @(negedge clk);
        csr_chipselect = 1'b0; csr_write = 1'b0;
    endtask

    task automatic csr_rd(input logic [1:0] a, output logic [31:0] d);
        @(negedge clk);
        csr_chipselect = 1'b1; csr_read = 1'b1; csr_address = a;
        @(negedge clk);
        csr_chipselect = 1'b0; csr_read = 1'b0;
        d = csr_readdata;
    endtask

    task automatic preload(input logic [10:0] a, input logic [31:0] d);
        @(negedge clk);
        pl_en = 1'b1; pl_addr = a; pl_data = d;
        @(negedge clk);
        pl_en = 1'b0;
        ref_mem[a] = d;
    endtask

    // Reference copy in strict ascending order; pushes expected s2 traffic
    task automatic push_copy(input logic [10:0] s, input logic [10:0] d, input int n);
        logic [10:0] sa, da;
        for (int i = 0; i < n; i++) begin
            sa = s + 11'(i);
            da = d + 11'(i);
            exp_rd_q.push_back(sa);
            exp_wr_q.push_back({da, ref_mem[sa]});
            ref_mem[da] = ref_mem[sa];
        end
    endtask

    task automatic wait_irq(input int c0, output int lat);
        int k;
        k = 0;
        while (irq !== 1'b1 && k < 300) begin
            @(negedge clk);
            k++;
        end
        lat = (irq === 1'b1) ? (cyc - c0) : -1;
    endtask

    task automatic test_reset();
        logic [31:0] d;
        n_checks++;
        if ({irq, mem_chipselect, mem_write, mem_address, mem_writedata, csr_readdata} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs irq=%b cs=%b wr=%b addr=%h wd=%h rd=%h required all 0",
                     irq, mem_chipselect, mem_write, mem_address, mem_writedata, csr_readdata);
        end
        n_checks++;
        if (mem_byteenable !== 4'hF || mem_clken !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_tieoffs be=%h clken=%b required F/1", mem_byteenable, mem_clken);
        end
        for (int a = 0; a < 4; a++) begin
            csr_rd(2'(a), d);
            n_checks++;
            if (d !== 32'd0) begin
                n_fail++;
                $display("FAIL reset_csr%0d got %h required 0", a, d);
            end
        end
    endtask

    task automatic test_basic();
        int c0, lat;
        logic [31:0] d;
        for (int i = 0; i < 4; i++) preload(11'h010 + 11'(i), 32'hA0A0_0000 + 32'(i));
        csr_wr(2'd1, 32'h010);
        csr_wr(2'd2, 32'h100);
        csr_wr(2'd3, 32'd4);
        push_copy(11'h010, 11'h100, 4);
        csr_wr(2'd0, 32'h5);
        c0 = cyc;
        wait_irq(c0, lat);
        n_checks++;
        if (lat != 12) begin
            n_fail++;
            $display("FAIL basic_latency got %0d required 12", lat);
        end
        csr_rd(2'd0, d);
        n_checks++;
        if (d !== 32'h6) begin
            n_fail++;
            $display("FAIL basic_ctrl got %h required 6", d);
        end
        csr_rd(2'd3, d);
        n_checks++;
        if (d !== 32'd0) begin
            n_fail++;
            $display("FAIL basic_len got %h required 0", d);
        end
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (ram[11'h100 + 11'(i)] !== 32'hA0A0_0000 + 32'(i)) begin
                n_fail++;
                $display("FAIL basic_mem%0d got %h required %h", i, ram[11'h100 + 11'(i)], 32'hA0A0_0000 + 32'(i));
            end
        end
    endtask

    task automatic test_len_zero();
        int cs0;
        logic [31:0] d;
        csr_wr(2'd0, 32'h8);
        n_checks++;
        if (irq !== 1'b0) begin
            n_fail++;
            $display("FAIL clear_irq got %b required 0", irq);
        end
        csr_wr(2'd3, 32'd0);
        cs0 = cs_count;
        csr_wr(2'd0, 32'h5);
        n_checks++;
        if (irq !== 1'b1) begin
            n_fail++;
            $display("FAIL len0_irq got %b required 1", irq);
        end
        csr_rd(2'd0, d);
        n_checks++;
        if (d !== 32'h6) begin
            n_fail++;
            $display("FAIL len0_ctrl got %h required 6", d);
        end
        n_checks++;
        if (cs_count != cs0) begin
            n_fail++;
            $display("FAIL len0_no_access got %0d accesses required 0", cs_count - cs0);
        end
    endtask

    task automatic test_wrap();
        int c0, lat;
        csr_wr(2'd0, 32'h8);
        preload(11'h7FE, 32'hB000_0000);
        preload(11'h7FF, 32'hB000_0001);
        preload(11'h000, 32'hB000_0002);
        preload(11'h001, 32'hB000_0003);
        csr_wr(2'd1, 32'h7FE);
        csr_wr(2'd2, 32'h7FF);
        csr_wr(2'd3, 32'd3);
        push_copy(11'h7FE, 11'h7FF, 3);
        csr_wr(2'd0, 32'h5);
        c0 = cyc;
        wait_irq(c0, lat);
        n_checks++;
        if (lat != 9) begin
            n_fail++;
            $display("FAIL wrap_latency got %0d required 9", lat);
        end
        n_checks++;
        if (ram[11'h7FF] !== 32'hB000_0000 || ram[11'h000] !== 32'hB000_0000 || ram[11'h001] !== 32'hB000_0000) begin
            n_fail++;
            $display("FAIL wrap_mem got %h %h %h required B0000000 x3", ram[11'h7FF], ram[11'h000], ram[11'h001]);
        end
    endtask

    task automatic test_abort();
        int w0;
        logic [31:0] d;
        csr_wr(2'd0, 32'h8);
        for (int i = 0; i < 8; i++) preload(11'h200 + 11'(i), 32'hC0C0_0000 + 32'(i));
        csr_wr(2'd1, 32'h200);
        csr_wr(2'd2, 32'h300);
        csr_wr(2'd3, 32'd8);
        push_copy(11'h200, 11'h300, 2);
        exp_rd_q.push_back(11'h202);
        w0 = wr_count;
        csr_wr(2'd0, 32'h5);
        repeat (6) @(negedge clk);
        csr_wr(2'd0, 32'h6);
        repeat (10) @(negedge clk);
        n_checks++;
        if (wr_count - w0 != 2) begin
            n_fail++;
            $display("FAIL abort_writes got %0d required 2", wr_count - w0);
        end
        n_checks++;
        if (irq !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_irq got %b required 0", irq);
        end
        csr_rd(2'd0, d);
        n_checks++;
        if (d !== 32'hC) begin
            n_fail++;
            $display("FAIL abort_ctrl got %h required c", d);
        end
        csr_rd(2'd3, d);
        n_checks++;
        if (d !== 32'd6) begin
            n_fail++;
            $display("FAIL abort_len got %h required 6", d);
        end
    endtask

    task automatic test_busy_ignore();
        int c0, lat;
        logic [31:0] d;
        csr_wr(2'd0, 32'h8);
        for (int i = 0; i < 4; i++) preload(11'h400 + 11'(i), 32'hD0D0_0000 + 32'(i));
        csr_wr(2'd1, 32'h400);
        csr_wr(2'd2, 32'h480);
        csr_wr(2'd3, 32'd4);
        push_copy(11'h400, 11'h480, 4);
        csr_wr(2'd0, 32'h5);
        c0 = cyc;
        csr_wr(2'd1, 32'h555);
        csr_wr(2'd0, 32'h9);
        wait_irq(c0, lat);
        n_checks++;
        if (lat != 12) begin
            n_fail++;
            $display("FAIL busy_latency got %0d required 12", lat);
        end
        csr_rd(2'd1, d);
        n_checks++;
        if (d !== 32'h400) begin
            n_fail++;
            $display("FAIL busy_src got %h required 400", d);
        end
        csr_rd(2'd0, d);
        n_checks++;
        if (d !== 32'h6) begin
            n_fail++;
            $display("FAIL busy_ctrl got %h required 6", d);
        end
    endtask

    task automatic test_queues_drained(input string name);
        n_checks++;
        if (exp_wr_q.size() != 0 || exp_rd_q.size() != 0) begin
            n_fail++;
            $display("FAIL %s_drain got wr=%0d rd=%0d pending required 0", name, exp_wr_q.size(), exp_rd_q.size());
        end
        exp_wr_q.delete();
        exp_rd_q.delete();
    endtask

    task automatic test_reset_midcopy();
        int w0;
        logic [31:0] d;
        csr_wr(2'd0, 32'h8);
        csr_wr(2'd1, 32'h600);
        csr_wr(2'd2, 32'h680);
        csr_wr(2'd3, 32'd16);
        sb_bypass = 1'b1;
        csr_wr(2'd0, 32'h5);
        repeat (3) @(negedge clk);
        n_checks++;
        if (mem_chipselect !== 1'b1) begin
            n_fail++;
            $display("FAIL midcopy_active got cs=%b required 1", mem_chipselect);
        end
        #2;
        reset_n = 1'b0;
        #1;
        n_checks++;
        if (mem_chipselect !== 1'b0 || mem_write !== 1'b0 || irq !== 1'b0) begin
            n_fail++;
            $display("FAIL midcopy_reset cs=%b wr=%b irq=%b required 0/0/0", mem_chipselect, mem_write, irq);
        end
        w0 = wr_count;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        repeat (10) @(negedge clk);
        n_checks++;
        if (wr_count != w0) begin
            n_fail++;
            $display("FAIL midcopy_no_writes got %0d writes required 0", wr_count - w0);
        end
        for (int a = 0; a < 4; a++) begin
            csr_rd(2'(a), d);
            n_checks++;
            if (d !== 32'd0 || irq !== 1'b0) begin
                n_fail++;
                $display("FAIL midcopy_csr%0d got %h irq=%b required 0/0", a, d, irq);
            end
        end
    endtask

    initial begin
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        test_reset();
        test_basic();
        test_queues_drained("basic");
        test_len_zero();
        test_wrap();
        test_queues_drained("wrap");
        test_abort();
        test_queues_drained("abort");
        test_busy_ignore();
        test_queues_drained("busy");
        test_reset_midcopy();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/dma_copy_engine.md
# dma_copy_engine

Memory-to-memory copy engine for the DMA controller subsystem. It masters the second port (s2) of the 2048 x 32 dual-port on-chip memory and copies a block of 32-bit words from a source word address to a destination word address inside that memory. The Nios/host side programs it through a four-register Avalon-MM CSR slave and is told of completion by a level interrupt. Port s1 of the same memory stays with the host, so the host can fill and drain buffers around each copy.

## Interface
- ADDR_W, 11: memory word-address width; depth 2^ADDR_W = 2048
- DATA_W, 32: memory data width
- LEN_W, 12: length-register width; legal lengths are 0..2048
- clk in 1: single clock, shared with the memory port s2 clock
- reset_n in 1: asynchronous, active-low reset
- csr_address in 2: CSR word select; 0 CTRL/STATUS, 1 SRC, 2 DST, 3 LEN
- csr_chipselect in 1: CSR select
- csr_write in 1: CSR write strobe
- csr_writedata in 32: CSR write data
- csr_read in 1: CSR read strobe
- csr_readdata out 32: CSR read data, registered, one cycle of read latency
- irq out 1: level interrupt, equal to done & irq_en
- mem_address out ADDR_W: port s2 word address
- mem_byteenable out 4: held at 4'hF
- mem_chipselect out 1: port s2 select
- mem_write out 1: port s2 write strobe
- mem_writedata out DATA_W: port s2 write data
- mem_readdata in DATA_W: port s2 read data; address is registered in the RAM, output is unregistered
- mem_clken out 1: held at 1

## Operation
- CTRL write bits:
  - bit0 start: ignored when busy.
  - bit1 abort.
  - bit2 irq_en: stored.
  - bit3 clear: clears done and aborted.
- CTRL read bits: bit0 busy, bit1 done, bit2 irq_en, bit3 aborted, rest 0.
- SRC and DST are ADDR_W-bit word addresses. LEN is the word count, LEN_W bits.
- Writes to SRC, DST or LEN while busy are ignored.
- A read of LEN returns the remaining count. It decrements after each WR.
- FSM, state in IDLE/RD/LAT/WR:
  - IDLE: on start with LEN = 0, set done at once and stay in IDLE. On start with LEN > 0, clear done and aborted, load the working pointers from SRC, DST and LEN, and go to RD.
  - RD: mem_chipselect=1, mem_write=0, mem_address=src_ptr. Go to LAT.
  - LAT: mem_chipselect=0. mem_readdata is valid this cycle; capture it into data_q. Go to WR.
  - WR: mem_chipselect=1, mem_write=1, mem_address=dst_ptr, mem_writedata=data_q. Increment both pointers modulo 2^ADDR_W and decrement the count. If the count reaches 0, set done and go to IDLE; otherwise go to RD.
- Pointer arithmetic wraps: 0x7FF + 1 = 0x000, with no error.
- Overlapping regions are copied strictly in ascending order. There is no overlap check; when dst > src and the regions overlap, source data is forward-propagated.
- Abort: when asserted in RD, LAT or WR, the FSM goes to IDLE at the next edge and sets aborted; done stays 0.
  - A WR presented in the same cycle as the abort still commits.
  - The remaining count is frozen.
  - Abort in IDLE has no effect.
- Start and abort in the same CSR write: abort takes priority.
- Start while busy: ignored entirely, including bit2 and bit3.
- Reset values:
  - FSM = IDLE.
  - All registers, csr_readdata and irq = 0.
  - mem_chipselect = 0, mem_write = 0, mem_address = 0, mem_writedata = 0.
  - mem_byteenable = F, mem_clken = 1.
- Reset asserted mid-copy: the FSM returns to IDLE immediately and no further memory cycle is issued.

## Timing
- A start written at edge t puts the FSM in RD during cycle t+1.
- Each word takes exactly 3 cycles: RD, LAT, WR.
- For N > 0 words, busy is high for 3N cycles. done and irq (when irq_en) rise at the edge that ends the last WR.
- CSR reads return data in the cycle after csr_read & csr_chipselect.
- CSR writes take effect at the edge where they are sampled.
- The mem_readdata capture in LAT relies on the RAM's single-cycle address-register latency. There is no combinational path from mem_readdata to any output.
- irq clears on the edge that samples clear; this is an edge, not a level.

## Structure
- Package dma_copy_pkg holds:
  - the state enum (IDLE, RD, LAT, WR);
  - CSR offsets (CSR_CTRL=0, CSR_SRC=1, CSR_DST=2, CSR_LEN=3);
  - CTRL bit positions (START=0, ABORT=1, IRQ_EN=2, CLEAR=3, and BUSY=0, DONE=1, ABORTED=3 for status).
- One natural sub-module is dma_copy_csr: register file, read mux, start/abort/clear pulses and irq.
- The FSM and datapath stay in the top module.
- At system level the memory's debugaccess is tied high so that port s2 writes take effect.

## Test plan
- Preload mem[0x010..0x013]=A0..A3; SRC=0x010, DST=0x100, LEN=4, start -> mem[0x100..0x103]=A0..A3; busy high 12 cycles; done=1; LEN reads 0.
- LEN=0, start -> done=1 on the next edge; no mem_chipselect pulse; irq=1 if irq_en.
- SRC=0x7FE, DST=0x7FF, LEN=3 with distinct data -> writes land at 0x7FF, 0x000, 0x001; reads come from 0x7FE, 0x7FF, 0x000; the overlap propagates the value of 0x7FE forward.
- LEN=8, abort written during the 3rd word's LAT -> exactly 2 words written; aborted=1, done=0, LEN reads 6; irq stays 0.
- During busy, write SRC=0x555 and start again -> both ignored; the original copy completes unchanged.
- Assert reset_n low mid-copy -> mem_chipselect=0 at once; all CSRs and irq read 0 after release; no further memory writes.
